// File: rtl/interconnect_cfg_loader.sv
// Serial bitstream loader that hunts for a sync word, then shifts in the per-CLB interconnect switch codes.
// Optional even-parity check on the payload is enabled by defining CFG_PARITY_EN.
module interconnect_cfg_loader #(
  parameter int          NUM_INPUTS   = 4,
  parameter int          SW_WIDTH     = 5,
  parameter logic [7:0]  SYNC_WORD    = 8'hA5,
  parameter int          SYNC_TIMEOUT = 255
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           cfg_start,
  input  logic                           cfg_valid,
  input  logic                           cfg_data,
  output logic                           cfg_ready,
  output logic [NUM_INPUTS*SW_WIDTH-1:0] switch_bus,
  output logic                           prgm_b,
  output logic                           CLB_prgm_b,
  output logic                           cfg_busy,
  output logic                           cfg_error
);

  localparam int PAYLOAD_W = NUM_INPUTS * SW_WIDTH;
  localparam int CNT_MAX   = (SYNC_TIMEOUT > PAYLOAD_W) ? SYNC_TIMEOUT : PAYLOAD_W;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

`ifdef CFG_PARITY_EN
  typedef enum logic [2:0] {IDLE, SYNC, LOAD, PARITY, COMMIT, DONE, ERROR} state_t;
`else
  typedef enum logic [2:0] {IDLE, SYNC, LOAD, COMMIT, DONE, ERROR} state_t;
`endif

  state_t                 state, state_next;
  logic [6:0]             sync_sr;      // older 7 bits; the incoming bit completes the 8-bit window
  logic [7:0]             sync_win;
  logic [CNT_W-1:0]       bit_cnt;
  logic [PAYLOAD_W-1:0]   payload;
  logic                   accept;
  logic                   clear_pass;
`ifdef CFG_PARITY_EN
  logic                   parity;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    clear_pass = 1'b0;
    cfg_ready  = 1'b0;
    cfg_busy   = 1'b0;
    cfg_error  = 1'b0;
    case (state)
      SYNC, LOAD: begin
        cfg_ready = 1'b1;
        cfg_busy  = 1'b1;
      end
`ifdef CFG_PARITY_EN
      PARITY: begin
        cfg_ready = 1'b1;
        cfg_busy  = 1'b1;
      end
`endif
      COMMIT:  cfg_busy  = 1'b1;
      ERROR:   cfg_error = 1'b1;
      default: ;
    endcase
    accept   = cfg_valid & cfg_ready;
    sync_win = {sync_sr, cfg_data};

    // A start pulse outranks any bit accepted in the same cycle
    if (cfg_start && state != COMMIT) begin
      state_next = SYNC;
      clear_pass = 1'b1;
    end else if (state == COMMIT) begin
      state_next = DONE;
    end else if (accept) begin
      case (state)
        SYNC: begin
          if (sync_win == SYNC_WORD)                     state_next = LOAD;
          else if (bit_cnt == CNT_W'(SYNC_TIMEOUT - 1))  state_next = ERROR;
        end
        LOAD: begin
          if (bit_cnt == CNT_W'(PAYLOAD_W - 1)) begin
`ifdef CFG_PARITY_EN
            state_next = PARITY;
`else
            state_next = COMMIT;
`endif
          end
        end
`ifdef CFG_PARITY_EN
        PARITY: state_next = (parity ^ cfg_data) ? ERROR : COMMIT;
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_sr    <= '0;
      bit_cnt    <= '0;
      payload    <= '0;
      switch_bus <= '0;
      prgm_b     <= 1'b0;
      CLB_prgm_b <= 1'b1;
`ifdef CFG_PARITY_EN
      parity     <= 1'b0;
`endif
    end else begin
      if (clear_pass) begin
        sync_sr    <= '0;
        bit_cnt    <= '0;
        CLB_prgm_b <= 1'b1;
`ifdef CFG_PARITY_EN
        parity     <= 1'b0;
`endif
      end else if (accept) begin
        if (state == SYNC) begin
          sync_sr <= sync_win[6:0];
          bit_cnt <= (sync_win == SYNC_WORD) ? '0 : bit_cnt + CNT_W'(1);
        end else if (state == LOAD) begin
          payload <= {payload[PAYLOAD_W-2:0], cfg_data};
          bit_cnt <= bit_cnt + CNT_W'(1);
`ifdef CFG_PARITY_EN
          parity  <= parity ^ cfg_data;
`endif
        end
      end
      if (state == COMMIT) begin
        switch_bus <= payload;
        prgm_b     <= 1'b1;
        CLB_prgm_b <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_interconnect_cfg_loader.sv
// Randomized bench for interconnect_cfg_loader, checked against a bitstream-level reference model.
// Follows the CFG_PARITY_EN setting of the build.
module tb_interconnect_cfg_loader;

  localparam int         NI   = 4;
  localparam int         SWW  = 5;
  localparam int         PW   = NI * SWW;
  localparam logic [7:0] SYNC = 8'hA5;
  localparam int         TO   = 255;
`ifdef CFG_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int RES_NONE = 0, RES_OK = 1, RES_ERR = 2;

  logic          clk = 1'b0;
  logic          reset, cfg_start, cfg_valid, cfg_data;
  logic          cfg_ready, prgm_b, CLB_prgm_b, cfg_busy, cfg_error;
  logic [PW-1:0] switch_bus;

  int            n_checks = 0;
  int            n_pass   = 0;
  logic [PW-1:0] exp_bus  = '0;
  logic          exp_prgm = 1'b0;

  interconnect_cfg_loader #(
    .NUM_INPUTS  (NI),
    .SW_WIDTH    (SWW),
    .SYNC_WORD   (SYNC),
    .SYNC_TIMEOUT(TO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cfg_start (cfg_start),
    .cfg_valid (cfg_valid),
    .cfg_data  (cfg_data),
    .cfg_ready (cfg_ready),
    .switch_bus(switch_bus),
    .prgm_b    (prgm_b),
    .CLB_prgm_b(CLB_prgm_b),
    .cfg_busy  (cfg_busy),
    .cfg_error (cfg_error)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference: walk the accepted bit stream of one pass and decide where and how it ends
  function automatic void model_pass(input bit s[$], output int n_used, output int res,
                                     output logic [PW-1:0] pl);
    logic [7:0] win = '0;
    int phase = 0, cnt = 0, k = 0;
    pl = '0; res = RES_NONE; n_used = s.size();
    for (int i = 0; i < s.size(); i++) begin
      if (phase == 0) begin
        win = {win[6:0], s[i]};
        cnt++;
        if (win == SYNC) phase = 1;
        else if (cnt == TO) begin res = RES_ERR; n_used = i + 1; return; end
      end else if (phase == 1) begin
        pl = {pl[PW-2:0], s[i]};
        k++;
        if (k == PW) begin
          if (PAR_EN) phase = 2;
          else begin res = RES_OK; n_used = i + 1; return; end
        end
      end else begin
        res = ((^pl) ^ s[i]) ? RES_ERR : RES_OK;
        n_used = i + 1;
        return;
      end
    end
  endfunction

  function automatic void build_stream(input logic [PW-1:0] pl, input bit par_good,
                                       input int junk, output bit s[$]);
    logic [7:0] sw = SYNC;
    s = {};
    for (int i = 0; i < junk; i++) s.push_back(bit'($urandom_range(0, 1)));
    for (int i = 7; i >= 0; i--) s.push_back(sw[i]);
    for (int i = PW - 1; i >= 0; i--) s.push_back(pl[i]);
    if (PAR_EN) s.push_back((^pl) ^ !par_good);
  endfunction

  task automatic start_pass(input bit valid_too);
    cfg_start = 1'b1;
    cfg_valid = valid_too;
    cfg_data  = 1'($urandom);
    @(negedge clk);
    cfg_start = 1'b0;
    cfg_valid = 1'b0;
  endtask

  task automatic send_bits(input bit s[$], input int n, input int max_gap);
    for (int i = 0; i < n; i++) begin
      int gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      repeat (gap) begin
        cfg_valid = 1'b0;
        cfg_data  = 1'($urandom);
        @(negedge clk);
      end
      check_eq("ready_in_pass", cfg_ready, 1'b1);
      cfg_valid = 1'b1;
      cfg_data  = s[i];
      @(negedge clk);
    end
    cfg_valid = 1'b0;
  endtask

  task automatic run_pass(input bit s[$], input int max_gap, input bit valid_too);
    int n_used, res;
    logic [PW-1:0] pl;
    model_pass(s, n_used, res, pl);
    start_pass(valid_too);
    check_eq("clb_in_pass", CLB_prgm_b, 1'b1);
    check_eq("busy_in_pass", cfg_busy, 1'b1);
    send_bits(s, n_used, max_gap);
    if (res == RES_OK) begin
      check_eq("commit_busy", cfg_busy, 1'b1);
      check_eq("commit_bus_held", switch_bus, exp_bus);
      @(negedge clk);
      exp_bus  = pl;
      exp_prgm = 1'b1;
      check_eq("done_bus", switch_bus, exp_bus);
      check_eq("done_prgm_b", prgm_b, 1'b1);
      check_eq("done_clb", CLB_prgm_b, 1'b0);
      check_eq("done_err", cfg_error, 1'b0);
      check_eq("done_busy", cfg_busy, 1'b0);
    end else begin
      check_eq("err_flag", cfg_error, 1'b1);
      check_eq("err_clb", CLB_prgm_b, 1'b1);
      check_eq("err_bus", switch_bus, exp_bus);
      check_eq("err_prgm_b", prgm_b, exp_prgm);
      check_eq("err_ready", cfg_ready, 1'b0);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_bus"}, switch_bus, '0);
    check_eq({tag, "_prgm_b"}, prgm_b, 1'b0);
    check_eq({tag, "_clb"}, CLB_prgm_b, 1'b1);
    check_eq({tag, "_ready"}, cfg_ready, 1'b0);
    check_eq({tag, "_busy"}, cfg_busy, 1'b0);
    check_eq({tag, "_err"}, cfg_error, 1'b0);
  endtask

  initial begin
    bit s[$];
    reset = 1'b1; cfg_start = 1'b0; cfg_valid = 1'b0; cfg_data = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_values("rst");
    reset = 1'b0;
    @(negedge clk);

    if (PAR_EN) begin
      build_stream(20'hB8DE0, 1'b0, 0, s);
      run_pass(s, 0, 1'b0);
      check_eq("badpar_bus_zero", switch_bus, 20'h0);
    end
    build_stream(20'hB8DE0, 1'b1, 0, s);
    run_pass(s, 0, 1'b0);
    check_eq("b8de0_bus", switch_bus, 20'hB8DE0);

    // Abort mid-LOAD after 10 payload bits; the bit presented with the start pulse is dropped
    build_stream(20'h12345, 1'b1, 0, s);
    start_pass(1'b0);
    send_bits(s, 18, 1);
    check_eq("abort_clb", CLB_prgm_b, 1'b1);
    check_eq("abort_bus_held", switch_bus, 20'hB8DE0);
    build_stream(20'h00421, 1'b1, 0, s);
    run_pass(s, 1, 1'b1);
    check_eq("00421_bus", switch_bus, 20'h00421);

    // Valid while not ready must change nothing
    for (int i = 0; i < 12; i++) begin
      cfg_valid = 1'b1;
      cfg_data  = 1'($urandom);
      @(negedge clk);
      check_eq("idle_valid_bus", switch_bus, exp_bus);
      check_eq("idle_valid_busy", cfg_busy, 1'b0);
    end
    cfg_valid = 1'b0;

    // Sync timeout
    s = {};
    repeat (TO) s.push_back(1'b0);
    start_pass(1'b0);
    send_bits(s, TO - 1, 0);
    check_eq("to_254_err", cfg_error, 1'b0);
    check_eq("to_254_ready", cfg_ready, 1'b1);
    send_bits(s, 1, 0);
    check_eq("to_255_err", cfg_error, 1'b1);
    check_eq("to_255_clb", CLB_prgm_b, 1'b1);
    check_eq("to_255_bus", switch_bus, exp_bus);

    // Asynchronous reset mid-LOAD, between clock edges
    build_stream(20'h5A5A5, 1'b1, 0, s);
    start_pass(1'b0);
    send_bits(s, 15, 3);
    cfg_valid = 1'b1;
    #2 reset = 1'b1;
    #1 check_reset_values("async_rst");
    cfg_valid = 1'b0;
    exp_bus  = '0;
    exp_prgm = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    build_stream(20'hB8DE0, 1'b1, 0, s);
    run_pass(s, 3, 1'b0);
    check_eq("post_rst_bus", switch_bus, 20'hB8DE0);

    for (int p = 0; p < 24; p++) begin
      build_stream(PW'($urandom), $urandom_range(0, 3) != 0, int'($urandom_range(0, 10)), s);
      run_pass(s, 2, 1'($urandom));
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/interconnect_cfg_loader.md
INTERCONNECT_CFG_LOADER -- requirements
Module: interconnect_cfg_loader

Interface
REQ-001 Parameter NUM_INPUTS, default 4, number of LUT-input interconnect switches programmed per CLB.
REQ-002 Parameter SW_WIDTH, default 5, width of one interconnect switch select code.
REQ-003 Parameter SYNC_WORD, default 8'hA5, bitstream sync pattern.
REQ-004 Parameter SYNC_TIMEOUT, default 255, maximum bits accepted in SYNC before abort.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 cfg_start  input  1  one-cycle pulse that begins or restarts a configuration pass.
REQ-008 cfg_valid  input  1  cfg_data is valid this cycle.
REQ-009 cfg_data  input  1  serial bitstream bit, MSB-first.
REQ-010 cfg_ready  output  1  loader accepts a bit this cycle.
REQ-011 switch_bus  output  NUM_INPUTS*SW_WIDTH  packed switch codes; field k is [k*SW_WIDTH +: SW_WIDTH] and drives interconnect_switch of LUT input k.
REQ-012 prgm_b  output  1  high once any configuration has been committed.
REQ-013 CLB_prgm_b  output  1  low means this CLB is configured and its interconnect muxes are live.
REQ-014 cfg_busy  output  1  high in SYNC, LOAD, PARITY and COMMIT.
REQ-015 cfg_error  output  1  high in ERROR.

Function
REQ-016 FSM states: IDLE, SYNC, LOAD, PARITY, COMMIT, DONE, ERROR.
REQ-017 A bit is accepted only when cfg_valid and cfg_ready are both 1; cfg_ready = 1 only in SYNC, LOAD and PARITY.
REQ-018 IDLE/DONE/ERROR + cfg_start -> SYNC; clear the sync shift register, bit counter and running parity.
REQ-019 SYNC: shift accepted bits into an 8-bit register; on the cycle the register including the current bit equals SYNC_WORD -> LOAD.
REQ-020 SYNC: if SYNC_TIMEOUT bits are accepted without a match -> ERROR.
REQ-021 LOAD: shift accepted bits into a payload register; after NUM_INPUTS*SW_WIDTH bits -> PARITY (macro defined) or COMMIT (macro undefined).
REQ-022 COMMIT: lasts exactly one cycle; switch_bus <= payload; prgm_b <= 1; CLB_prgm_b <= 0; -> DONE. switch_bus updates on the edge after COMMIT, i.e. 2 cycles after the last payload bit.
REQ-023 The loader does not range-check switch codes; codes above 5'b10111 are loaded unchanged (the interconnect mux drives them as unused/z).
REQ-024 cfg_start in SYNC, LOAD or PARITY aborts and restarts at SYNC; it takes priority over a bit accepted in the same cycle, which is discarded.
REQ-025 During any pass (SYNC through COMMIT), CLB_prgm_b = 1; switch_bus holds its previous value until COMMIT.
REQ-026 ERROR: CLB_prgm_b = 1; switch_bus and prgm_b hold their previous values; remain in ERROR until cfg_start.
REQ-027 cfg_valid while cfg_ready = 0 is ignored, with no state change.

Reset
REQ-028 Asserting reset at any time, including mid-pass, forces IDLE immediately, without waiting for a clock edge.
REQ-029 Reset values: switch_bus = 0, prgm_b = 0, CLB_prgm_b = 1, cfg_ready = 0, cfg_busy = 0, cfg_error = 0; all counters and shift registers = 0.

Configuration
REQ-030 Macro CFG_PARITY_EN defined: the PARITY state accepts one bit, and the XOR of the payload and this bit must equal 0 (even parity). Match -> COMMIT; mismatch -> ERROR.
REQ-031 Macro CFG_PARITY_EN undefined: no PARITY state and no parity logic; LOAD goes directly to COMMIT.

Verification
REQ-032 Default parameters, CFG_PARITY_EN defined: cfg_start, then bits 10100101, then payload 20'hB8DE0 MSB-first, then parity bit 0 -> switch_bus = 20'hB8DE0 two cycles after the parity bit, with prgm_b = 1, CLB_prgm_b = 0, cfg_error = 0.
REQ-033 Same stimulus with parity bit 1 -> ERROR, cfg_error = 1, CLB_prgm_b = 1, and switch_bus remains 0.
REQ-034 Program 20'hB8DE0, then start a second pass and pulse cfg_start after 10 payload bits; then send sync plus 20'h00421 (parity 1) -> CLB_prgm_b = 1 during the pass, and finally switch_bus = 20'h00421 with CLB_prgm_b = 0.
REQ-035 cfg_start, then 255 zero bits -> ERROR asserted on the cycle after the 255th bit.
REQ-036 Assert reset asynchronously mid-LOAD, with cfg_valid toggling and cfg_valid held low for gaps -> all outputs take their reset values before the next clk edge; the gaps cause no bit loss in a later complete pass.
